sync_hs_dst: RTL

Destination-domain receiver for a toggle-based, four-phase-free bus handshake crossing into clk.
- The source flips src_req_tgl once per word and holds src_data stable until it sees ack_tgl flip.
- This block synchronises the request toggle through a multi-flop chain and detects the change.
- It captures the word, presents it on a valid/ready interface, then flips ack_tgl back to the source domain.
- It sits directly downstream of the raw asynchronous request line and feeds core-side consumers.

---
 rtl/sync_hs_dst_pkg.sv | 17 +
 rtl/sync_chain_sr.sv | 24 ++
 rtl/sync_hs_dst.sv | 111 +++++++++++
 3 files changed

// File: rtl/sync_hs_dst_pkg.sv
// Shared types and constants for the toggle-handshake destination receiver.
// Holds the FSM state encoding and the legal synchroniser depth range.
package sync_hs_dst_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    localparam int unsigned SyncStagesMin = 2;
    localparam int unsigned SyncStagesMax = 4;

    function automatic bit stages_legal(input int unsigned stages);
        return (stages >= SyncStagesMin) && (stages <= SyncStagesMax);
    endfunction

endpackage

// File: rtl/sync_chain_sr.sv
// Multi-flop 1-bit synchroniser with synchronous active-high reset to 0.
// Output is the last flop of the chain.
module sync_chain_sr #(
    parameter int unsigned STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_hs_dst.sv
// Destination side of a toggle request/ack crossing: detects a new request toggle,
// captures the quasi-static source word and offers it on a valid/ready port.
module sync_hs_dst
    import sync_hs_dst_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_req_tgl,
    input  logic [DW-1:0] src_data,
    output logic          ack_tgl,
    output logic          dst_valid,
    input  logic          dst_ready,
    output logic [DW-1:0] dst_data,
    output logic          err_ovf,
    output logic [CW-1:0] xfer_cnt
);

    state_e        state_q, state_d;
    logic          req_s;
    logic          pending;
    logic          last_req_q, last_req_d;
    logic          ack_q, ack_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    sync_chain_sr #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (src_req_tgl),
        .q   (req_s)
    );

    assign pending = (req_s != last_req_q);

    always_comb begin
        state_d    = state_q;
        last_req_d = last_req_q;
        ack_d      = ack_q;
        valid_d    = valid_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pending) begin
                    data_d     = src_data;
                    valid_d    = 1'b1;
                    last_req_d = req_s;
                    state_d    = StHold;
                end
            end
            StHold: begin
                // A toggle seen here means the source moved on before being acked.
                if (pending) begin
                    ovf_d = 1'b1;
                end
                if (dst_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_req_q <= 1'b0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_req_q <= last_req_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack_tgl   = ack_q;
    assign dst_valid = valid_q;
    assign dst_data  = data_q;
    assign err_ovf   = ovf_q;
    assign xfer_cnt  = cnt_q;

    a_stages_legal: assert property (@(posedge clk) stages_legal(SYNC_STAGES));

    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (dst_valid && !dst_ready) |=> (dst_valid && $stable(dst_data) && $stable(ack_tgl)));

    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst) err_ovf |=> err_ovf);

endmodule
